// File: rtl/ex_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_trace_buffer_if
//  Purpose  : Capture bus from the EX stage plus the valid/ready read port.
//  Revision : 1.0  initial release
// ============================================================================
interface ex_trace_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int SEL_WIDTH  = 5
);
    logic                  cap_valid;
    logic [PC_WIDTH-1:0]   cap_pc;
    logic [DATA_WIDTH-1:0] cap_op1;
    logic [DATA_WIDTH-1:0] cap_op2;
    logic [SEL_WIDTH-1:0]  cap_sel;
    logic [DATA_WIDTH-1:0] cap_result;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [PC_WIDTH-1:0]   rd_pc;
    logic [DATA_WIDTH-1:0] rd_op1;
    logic [DATA_WIDTH-1:0] rd_op2;
    logic [SEL_WIDTH-1:0]  rd_sel;
    logic [DATA_WIDTH-1:0] rd_result;

    modport master (
        output cap_valid, cap_pc, cap_op1, cap_op2, cap_sel, cap_result, rd_ready,
        input  rd_valid, rd_pc, rd_op1, rd_op2, rd_sel, rd_result
    );

    modport slave (
        input  cap_valid, cap_pc, cap_op1, cap_op2, cap_sel, cap_result, rd_ready,
        output rd_valid, rd_pc, rd_op1, rd_op2, rd_sel, rd_result
    );
endinterface
`default_nettype wire

// File: rtl/ex_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : ex_trace_buffer
//  Purpose  : Arm/trigger controlled circular capture of EX-stage ALU events,
//             drained oldest-first over a valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
module ex_trace_buffer #(
    parameter  int DATA_WIDTH = 32,
    parameter  int PC_WIDTH   = 32,
    parameter  int SEL_WIDTH  = 5,
    parameter  int DEPTH      = 8,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = AW + 1
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    ex_trace_buffer_if.slave         bus,
    input  wire logic                arm,
    input  wire logic                mode,
    input  wire logic [PC_WIDTH-1:0] trig_pc,
    input  wire logic [CW-1:0]       post_count,
    output logic      [CW-1:0]       count,
    output logic      [1:0]          state,
    output logic                     overflow
);

    localparam int REC_W = PC_WIDTH + 3 * DATA_WIDTH + SEL_WIDTH;
    localparam logic [CW-1:0] c_max_post = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    logic [REC_W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]       r_wp;
    logic [AW-1:0]       r_rp;
    logic [AW-1:0]       r_remain;
    logic [AW-1:0]       r_post;
    logic [CW-1:0]       r_count;
    logic                r_overflow;
    logic                r_mode;
    logic [PC_WIDTH-1:0] r_trig;

    logic [AW-1:0]       w_post_sat;
    logic                w_wr;
    logic                w_full;
    logic                w_rd_valid;
    logic                w_rd_fire;
    logic                w_trig_hit;
    logic [REC_W-1:0]    w_rec;

    assign w_post_sat = (post_count > c_max_post) ? AW'(DEPTH - 1) : post_count[AW-1:0];
    // ARM takes priority over a coincident sample, so it suppresses the write
    assign w_wr       = !arm && bus.cap_valid && (r_state == S_CAPTURE || r_state == S_POST);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_rd_valid = (r_state == S_DONE) && (r_count != '0);
    assign w_rd_fire  = w_rd_valid && bus.rd_ready;
    assign w_trig_hit = (bus.cap_pc == r_trig);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wp       <= '0;
            r_rp       <= '0;
            r_remain   <= '0;
            r_post     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_mode     <= 1'b0;
            r_trig     <= '0;
        end else if (arm) begin
            r_state    <= S_CAPTURE;
            r_wp       <= '0;
            r_rp       <= '0;
            r_remain   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_mode     <= mode;
            r_trig     <= trig_pc;
            r_post     <= w_post_sat;
        end else if (w_wr) begin
            r_wp <= r_wp + AW'(1);
            if (!w_full) begin
                r_count <= r_count + CW'(1);
            end else begin
                // Full: the oldest record is dropped by advancing the read side
                r_rp       <= r_rp + AW'(1);
                r_overflow <= 1'b1;
            end
            case (r_state)
                S_CAPTURE: begin
                    if (!r_mode) begin
                        if (r_count == CW'(DEPTH - 1)) r_state <= S_DONE;
                    end else if (w_trig_hit) begin
                        if (r_post == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_remain <= r_post;
                            r_state  <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    r_remain <= r_remain - AW'(1);
                    if (r_remain == AW'(1)) r_state <= S_DONE;
                end
                default: ;
            endcase
        end else if (w_rd_fire) begin
            r_rp    <= r_rp + AW'(1);
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= {bus.cap_pc, bus.cap_op1, bus.cap_op2, bus.cap_sel, bus.cap_result};
        end
    end

    assign w_rec         = w_rd_valid ? r_mem[r_rp] : '0;
    assign bus.rd_valid  = w_rd_valid;
    assign {bus.rd_pc, bus.rd_op1, bus.rd_op2, bus.rd_sel, bus.rd_result} = w_rec;

    assign count    = r_count;
    assign state    = r_state;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ex_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_trace_buffer
//  Purpose  : Directed and random stimulus against a queue-based trace model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_trace_buffer;
    localparam int DW    = 32;
    localparam int PW    = 32;
    localparam int SW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [SW-1:0] sel;
        logic [DW-1:0] res;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          arm;
    logic          mode;
    logic [PW-1:0] trig_pc;
    logic [CW-1:0] post_count;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic          overflow;

    always #5 clk = ~clk;

    ex_trace_buffer_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .SEL_WIDTH(SW)) bus ();

    ex_trace_buffer #(
        .DATA_WIDTH(DW), .PC_WIDTH(PW), .SEL_WIDTH(SW), .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .arm        (arm),
        .mode       (mode),
        .trig_pc    (trig_pc),
        .post_count (post_count),
        .count      (count),
        .state      (state),
        .overflow   (overflow)
    );

    int   n_checks = 0;
    int   n_errors = 0;

    rec_t          q[$];
    int            m_state;
    bit            m_ovf;
    bit            m_mode;
    logic [PW-1:0] m_trig;
    int            m_post;
    int            m_remain;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state  = 0;
        m_ovf    = 0;
        m_remain = 0;
    endtask

    // Queue view: the buffer keeps at most DEPTH newest records, oldest at q[0]
    task automatic model_step();
        rec_t r;
        if (!reset_n) begin
            model_reset();
        end else if (arm) begin
            q.delete();
            m_ovf    = 0;
            m_mode   = mode;
            m_trig   = trig_pc;
            m_post   = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
            m_remain = 0;
            m_state  = 1;
        end else if ((m_state == 1 || m_state == 2) && bus.cap_valid) begin
            r = '{bus.cap_pc, bus.cap_op1, bus.cap_op2, bus.cap_sel, bus.cap_result};
            q.push_back(r);
            if (q.size() > DEPTH) begin
                void'(q.pop_front());
                m_ovf = 1;
            end
            if (m_state == 1) begin
                if (!m_mode) begin
                    if (q.size() == DEPTH) m_state = 3;
                end else if (bus.cap_pc == m_trig) begin
                    if (m_post == 0) m_state = 3;
                    else begin
                        m_remain = m_post;
                        m_state  = 2;
                    end
                end
            end else begin
                m_remain--;
                if (m_remain == 0) m_state = 3;
            end
        end else if (m_state == 3 && q.size() > 0 && bus.rd_ready) begin
            void'(q.pop_front());
        end
    endtask

    task automatic check_outputs();
        rec_t h;
        bit   v;
        v = (m_state == 3) && (q.size() > 0);
        h = v ? q[0] : '0;
        chk("state",     64'(state),          64'(m_state));
        chk("count",     64'(count),          64'(q.size()));
        chk("overflow",  64'(overflow),       64'(m_ovf));
        chk("rd_valid",  64'(bus.rd_valid),   64'(v));
        chk("rd_pc",     64'(bus.rd_pc),      64'(h.pc));
        chk("rd_op1",    64'(bus.rd_op1),     64'(h.op1));
        chk("rd_op2",    64'(bus.rd_op2),     64'(h.op2));
        chk("rd_sel",    64'(bus.rd_sel),     64'(h.sel));
        chk("rd_result", 64'(bus.rd_result),  64'(h.res));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_sample(input logic [PW-1:0] pc);
        bus.cap_valid  = 1'b1;
        bus.cap_pc     = pc;
        bus.cap_op1    = $urandom;
        bus.cap_op2    = $urandom;
        bus.cap_sel    = SW'($urandom);
        bus.cap_result = $urandom;
    endtask

    task automatic do_arm(input bit md, input logic [PW-1:0] tp, input logic [CW-1:0] pcnt);
        arm           = 1'b1;
        mode          = md;
        trig_pc       = tp;
        post_count    = pcnt;
        bus.cap_valid = 1'b0;
        tick();
        arm = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.cap_valid = 1'b0;
        bus.rd_ready  = 1'b1;
        for (int i = 0; i < n; i++) tick();
        bus.rd_ready  = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        arm            = 1'b0;
        mode           = 1'b0;
        trig_pc        = '0;
        post_count     = '0;
        bus.cap_valid  = 1'b0;
        bus.cap_pc     = '0;
        bus.cap_op1    = '0;
        bus.cap_op2    = '0;
        bus.cap_sel    = '0;
        bus.cap_result = '0;
        bus.rd_ready   = 1'b0;
        model_reset();
        m_mode = 0; m_trig = '0; m_post = 0;

        #12;
        check_outputs();
        reset_n = 1'b1;
        tick();
        tick();

        // Fill-and-stop: only the first DEPTH samples are kept
        do_arm(1'b0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            set_sample(PW'(i * 4));
            tick();
        end
        drain(6);

        // Circular with trigger at 0x18 and one post-trigger record
        do_arm(1'b1, 32'h18, CW'(1));
        for (int i = 0; i < 10; i++) begin
            set_sample(PW'(i * 4));
            tick();
        end
        drain(6);

        // Trigger on the 2nd sample with no post records; later samples ignored
        do_arm(1'b1, 32'h04, CW'(0));
        for (int i = 0; i < 4; i++) begin
            set_sample(PW'(i * 4));
            tick();
        end
        drain(4);

        // Back-pressure with three records held
        do_arm(1'b1, 32'h08, CW'(0));
        for (int i = 0; i < 3; i++) begin
            set_sample(PW'(i * 4));
            tick();
        end
        bus.cap_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        drain(4);

        // ARM coincident with a sample at COUNT=2
        do_arm(1'b0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            set_sample(PW'(i * 4));
            tick();
        end
        set_sample(32'h40);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        bus.cap_valid = 1'b0;
        tick();

        // Asynchronous reset while in POST with three records
        do_arm(1'b1, 32'h08, CW'(3));
        for (int i = 0; i < 3; i++) begin
            set_sample(PW'(i * 4));
            tick();
        end
        bus.cap_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_sample(PW'(i * 4));
            bus.rd_ready = 1'b1;
            tick();
        end
        bus.rd_ready = 1'b0;

        // Random traffic with occasional re-arms, including saturating POST_COUNT
        for (int i = 0; i < 3000; i++) begin
            arm = ($urandom_range(0, 39) == 0);
            if (arm) begin
                mode       = 1'($urandom);
                trig_pc    = PW'($urandom_range(0, 15) * 4);
                post_count = CW'($urandom_range(0, (1 << CW) - 1));
            end
            if ($urandom_range(0, 3) != 0) set_sample(PW'($urandom_range(0, 15) * 4));
            else bus.cap_valid = 1'b0;
            bus.rd_ready = 1'($urandom);
            tick();
        end
        arm = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ex_trace_buffer.md
# ex_trace_buffer

Synthesizable, parametrised execution-trace capture block for the RV32IM pipeline. It records EX-stage ALU events (PC, both operands, ALU select, result) into an on-chip circular buffer under an arm/trigger state machine. After capture it streams the records out oldest-first over a valid/ready port. It sits beside the EX stage, fed from the EX/MEM boundary signals, and gives on-silicon visibility of the ALU activity the simulation monitor prints.

## Interface
- DATA_WIDTH, 32, width of operands and result
- PC_WIDTH, 32, width of captured PC
- SEL_WIDTH, 5, width of ALU select code
- DEPTH, 8, entries in buffer; power of two, >= 2; AW = clog2(DEPTH)

- CLK  in  1  clock, all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CAP_VALID  in  1  EX stage holds a valid instruction this cycle
- CAP_PC  in  PC_WIDTH  PC of EX instruction
- CAP_OP1 / CAP_OP2  in  DATA_WIDTH  ALU operands after forwarding
- CAP_SEL  in  SEL_WIDTH  ALU select
- CAP_RESULT  in  DATA_WIDTH  ALU result
- ARM  in  1  single-cycle pulse: clear buffer, start capture
- MODE  in  1  0 = fill-and-stop, 1 = circular with PC trigger; sampled on ARM
- TRIG_PC  in  PC_WIDTH  trigger PC, sampled on ARM
- POST_COUNT  in  AW+1  entries to record after the trigger entry, sampled on ARM; values above DEPTH-1 saturate to DEPTH-1
- RD_VALID  out  1  record available on RD_* outputs
- RD_READY  in  1  consumer accepts record
- RD_PC, RD_OP1, RD_OP2, RD_SEL, RD_RESULT  out  as CAP_*  oldest unread record; all zero when RD_VALID=0
- COUNT  out  AW+1  records currently held
- STATE  out  2  0 IDLE, 1 CAPTURE, 2 POST, 3 DONE
- OVERFLOW  out  1  sticky: at least one record overwritten since ARM

## Operation
- Storage: DEPTH-entry register array with write pointer WP, read pointer RP (AW bits, wrap modulo DEPTH) and COUNT. The array itself is not reset.
- IDLE: nothing is written. ARM clears WP, RP, COUNT and OVERFLOW, latches MODE/TRIG_PC/POST_COUNT, then moves to CAPTURE.
- CAPTURE, write rule: on CAP_VALID, write the entry at WP and increment WP.
  - If COUNT < DEPTH, COUNT increments.
  - Otherwise (mode 1 only) RP increments, COUNT holds, and OVERFLOW is set.
- CAPTURE, MODE=0: the write that brings COUNT to DEPTH moves the state to DONE. No trigger is evaluated.
- CAPTURE, MODE=1: on CAP_VALID with CAP_PC==TRIG_PC, the trigger entry is written.
  - Latched POST_COUNT 0: go to DONE.
  - Otherwise: load REMAIN = POST_COUNT and go to POST.
- POST: each CAP_VALID writes using the circular rule and decrements REMAIN. The write that takes REMAIN from 1 to 0 moves the state to DONE. A TRIG_PC match here has no special effect.
- DONE: no capture.
  - RD_VALID = (COUNT != 0).
  - A handshake (RD_VALID && RD_READY) increments RP and decrements COUNT.
  - After draining, the block stays in DONE with RD_VALID=0.
- ARM in any state restarts: same clear as from IDLE, state goes to CAPTURE.
- Simultaneous events:
  - ARM with CAP_VALID: ARM wins and the sample is dropped.
  - ARM with a read handshake: ARM wins and the record counts as not consumed.
  - In non-DONE states RD_READY is ignored.
- Reset mid-operation: all state clears immediately and the block sits in IDLE; no record is output.

## Timing
- Reset values: STATE=0 (IDLE), COUNT=0, OVERFLOW=0, RD_VALID=0, all RD_* data 0. REMAIN, WP and RP are all 0.
- Capture latency: a sample present at edge N is counted in COUNT after edge N.
- Read path: RD_* are combinational from the array at RP and are valid in the same cycle as RD_VALID. Throughput is one record per cycle while RD_READY=1.
- State transition to DONE happens on the same edge as the final write. RD_VALID can be 1 the following cycle.
- RD_* are stable while RD_VALID=1 and RD_READY=0.

## Test plan
- DEPTH=4, MODE=0, ARM, then 6 valid samples with PC 0x00,0x04,…,0x14:
  - After the 4th sample, STATE=3 and COUNT=4.
  - The read returns PC 0x00,0x04,0x08,0x0C, then RD_VALID=0, with OVERFLOW=0.
- DEPTH=4, MODE=1, TRIG_PC=0x18, POST_COUNT=1, samples with PC 0x00..0x24 step 4:
  - After the 0x1C write, STATE=3 and OVERFLOW=1.
  - The read returns 0x10,0x14,0x18,0x1C.
- MODE=1, POST_COUNT=0, trigger on the 2nd sample:
  - DONE on the same edge; COUNT=2.
  - Following samples are ignored (COUNT stays 2).
- Back-pressure: in DONE with COUNT=3, hold RD_READY=0 for 3 cycles, then 1:
  - RD_* are unchanged while stalled.
  - Three records follow on consecutive cycles, and COUNT ends at 0.
- ARM together with CAP_VALID in CAPTURE at COUNT=2:
  - Next cycle COUNT=0, STATE=1, OVERFLOW=0, and the concurrent sample is absent.
- Assert RESET_N=0 asynchronously in POST with COUNT=3:
  - All outputs go to reset values before the next edge.
  - After release, STATE stays 0 until ARM.
